// File: rtl/apb_timer_regbank.sv
// APB3 register bank for NUM_CH timer channels (TDR/TCR/TSR per channel, 4-word stride).
// Optional feature: define TIMER_IRQ_EN for TCR[3:2] interrupt enables and a registered irq output.
module apb_timer_regbank #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CH      = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  output logic [DATA_WIDTH-1:0]        prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [NUM_CH-1:0]            s_ovf,
  input  logic [NUM_CH-1:0]            s_udf,
  output logic [NUM_CH*DATA_WIDTH-1:0] tdr_reg,
  output logic [NUM_CH*DATA_WIDTH-1:0] tcr_reg,
  output logic [NUM_CH*DATA_WIDTH-1:0] tsr_reg
`ifdef TIMER_IRQ_EN
  ,
  output logic [NUM_CH-1:0]            irq
`endif
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]         WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] NUM_CH_A  = ADDR_WIDTH'(NUM_CH);
`ifdef TIMER_IRQ_EN
  localparam logic [7:0] TCR_MASK8 = 8'hBF;
`else
  localparam logic [7:0] TCR_MASK8 = 8'hB3;
`endif
  localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(TCR_MASK8);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d, phase;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ch_idx;
  logic [1:0]              offset;
  logic                    addr_err;
  logic                    wr_en;

  assign ch_idx   = paddr >> 2;
  assign offset   = paddr[1:0];
  assign addr_err = (offset == 2'd3) || (ch_idx >= NUM_CH_A);
  assign wr_en    = pready && pwrite && !addr_err;

  // The SETUP phase is the bus cycle carrying psel & ~penable, so it is decoded
  // from IDLE plus the inputs; this puts pready in the right ACCESS cycle.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && psel && !penable) phase = SETUP;
  end

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    // NOTE: sequential state uses nonblocking assignments so all flops sample together.
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (phase)
      IDLE:   state_d = IDLE;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LOAD;
      end
      ACCESS: begin
        if (!psel)              state_d = IDLE;
        else if (cnt_q != '0)   cnt_d   = cnt_q - 1'b1;
        else if (penable)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pready  = (state_q == ACCESS) && (cnt_q == '0) && psel && penable;
    pslverr = pready && addr_err;
    prdata  = '0;
    if (pready && !pwrite && !addr_err) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_idx == ADDR_WIDTH'(i)) begin
          unique case (offset)
            2'd0:    prdata = tdr_reg[i*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    prdata = tcr_reg[i*DATA_WIDTH +: DATA_WIDTH];
            2'd2:    prdata = tsr_reg[i*DATA_WIDTH +: DATA_WIDTH];
            default: prdata = '0;
          endcase
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] tdr_q, tcr_q;
    logic [1:0]            tsr_q;
    logic                  sel, clr_ovf, clr_udf;

    assign sel     = wr_en && (ch_idx == ADDR_WIDTH'(c));
    assign clr_ovf = sel && (offset == 2'd2) && pwdata[0];
    assign clr_udf = sel && (offset == 2'd2) && pwdata[1];

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        tdr_q <= '0;
        tcr_q <= '0;
        tsr_q <= '0;
      end else begin
        if (sel && offset == 2'd0) tdr_q <= pwdata;
        if (sel && offset == 2'd1) tcr_q <= pwdata & TCR_MASK;
        // A set event in the same cycle as a clear wins.
        tsr_q[0] <= s_ovf[c] | (tsr_q[0] & ~clr_ovf);
        tsr_q[1] <= s_udf[c] | (tsr_q[1] & ~clr_udf);
      end
    end

    assign tdr_reg[c*DATA_WIDTH +: DATA_WIDTH] = tdr_q;
    assign tcr_reg[c*DATA_WIDTH +: DATA_WIDTH] = tcr_q;
    assign tsr_reg[c*DATA_WIDTH +: DATA_WIDTH] = {{(DATA_WIDTH-2){1'b0}}, tsr_q};

`ifdef TIMER_IRQ_EN
    logic irq_q;
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) irq_q <= 1'b0;
      else          irq_q <= |(tsr_q & tcr_q[3:2]);
    end
    assign irq[c] = irq_q;
`endif
  end

endmodule

// File: doc/apb_timer_regbank.md
Name: apb_timer_regbank

Overview:
- Parametrised successor of the single-timer APB register block.
- Holds NUM_CH independent timer register sets (TDR/TCR/TSR) behind one APB3 slave.
- Supports programmable wait states, per-bit write-1-to-clear status and a fully decoded address map.
- Sits between the APB interconnect and NUM_CH counter cores, which consume TDR/TCR and pulse ovf/udf events back.

Parameters:
- ADDR_WIDTH, 8, APB address width; must satisfy 2^ADDR_WIDTH >= 4*NUM_CH.
- DATA_WIDTH, 8, APB data width and register width; minimum 8.
- NUM_CH, 4, number of timer channels; range 1..16.
- WAIT_CYCLES, 0, wait states inserted in every ACCESS phase; range 0..15.

Ports:
- pclk  in  1  APB clock; the only clock.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte-independent word index.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; valid while pready=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error; valid only while pready=1.
- s_ovf  in  NUM_CH  per-channel overflow event, 1-cycle pulse or level.
- s_udf  in  NUM_CH  per-channel underflow event.
- tdr_reg  out  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- tcr_reg  out  NUM_CH*DATA_WIDTH  packed the same way.
- tsr_reg  out  NUM_CH*DATA_WIDTH  packed the same way.

Behaviour:
- Clock and reset: one clock (pclk). Reset presetn is asynchronous, active-low; deassertion is sampled on a pclk rising edge.
- Reset values: all registers 0, FSM in IDLE, pready=0, pslverr=0, prdata=0.
- Address map: channel c = paddr/4, offset = paddr%4.
  - Offset 0 = TDR; 1 = TCR; 2 = TSR; 3 = reserved.
  - Error when offset == 3 or c >= NUM_CH.
- FSM: IDLE -> SETUP on psel & ~penable. SETUP -> ACCESS on the next cycle (wait counter loaded with WAIT_CYCLES).
  - In ACCESS, the counter decrements each cycle while nonzero.
  - pready = 1 when the counter is 0 and psel & penable; then the FSM returns to IDLE, or to SETUP if psel & ~penable follows back-to-back.
  - Latency: pready is high in the (WAIT_CYCLES+1)th ACCESS cycle.
  - psel dropping during ACCESS: abort to IDLE, no register update, no pready.
- pready and pslverr are combinational from state and counter; both are 0 outside the completing cycle.
- Write commits on the pclk edge ending the pready=1 cycle, and only if there is no error.
  - TDR: full pwdata.
  - TCR: bits [7], [5:4], [1:0] from pwdata; bits [6], [3:2] and [DATA_WIDTH-1:8] forced to 0.
  - TSR: W1C per bit. Bit0 (ovf) is cleared if pwdata[0]=1; bit1 (udf) is cleared if pwdata[1]=1. Bits are independent. Upper bits always read 0.
- Read: prdata = selected register during the pready=1 cycle; 0 at all other times, and 0 on error.
- Error access: pslverr=1 with pready, no state change, prdata=0.
- Status set: each cycle, tsr bit0 of channel c is set if s_ovf[c]=1 (bit1 likewise from s_udf[c]). This is sticky and fully synchronous.
  - Set and W1C clear in the same cycle: set wins, bit stays 1.
- Channels are fully independent; a write to one channel never alters another.
- Reset mid-transfer: everything returns immediately to reset values. The interrupted transfer is dropped; the master must reissue it.

Optional Feature:
- Macro: TIMER_IRQ_EN.
- When defined:
  - TCR bits [3:2] become writable interrupt enables (bit2 = ovf, bit3 = udf).
  - An added output irq [NUM_CH] is asserted, registered, as irq[c] = |(tsr[1:0] & tcr[3:2]).
  - irq is 0 at reset and falls 1 cycle after the enabling status bit is cleared.
- When undefined: TCR[3:2] stay forced to 0 and the irq port does not exist.

Test Plan:
- WAIT_CYCLES=0: write 0xA5 to paddr 0x04, then read 0x04 -> pready in the first ACCESS cycle, prdata=0xA5, tdr_reg ch1=0xA5, other channels 0.
- WAIT_CYCLES=3: write 0xFF to TCR ch0 (paddr 0x01) -> pready after exactly 3 wait cycles, tcr ch0 = 0xB3.
- s_ovf[2] pulse, then write 0x02 to paddr 0x0A -> tsr ch2 stays 0x01. Next write 0x01 -> tsr ch2 = 0x00.
- s_udf[0] high in the same cycle as a W1C of 0x02 to paddr 0x02 -> tsr ch0 bit1 remains 1.
- NUM_CH=4: read paddr 0x10 and 0x03 -> pslverr=1, prdata=0, no register changes.
- Reset asserted during an ACCESS wait state -> pready=0 immediately, all registers 0, next transfer completes normally.
